// File: rtl/fp_div_operand_feeder_pkg.sv
// Shared types and helpers for the divider operand feeder.
// The FSM state set always includes READ; it is only reachable when FP_DIV_FEEDER_READBACK_EN is defined.
package fp_div_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SET,
    UNLOCK,
    GO,
    WAIT,
    READ,
    DONE
  } feeder_state_t;

  localparam int NUM_OPERAND_BYTES = 8;
  localparam int NUM_RESULT_BYTES  = 4;
  localparam logic [2:0] LAST_OPERAND_IDX = 3'(NUM_OPERAND_BYTES - 1);

  // Byte k of the concatenated operands, A first, each one LSB first.
  function automatic logic [7:0] byte_of(input logic [31:0] opA,
                                         input logic [31:0] opB,
                                         input logic [2:0]  k);
    logic [63:0] both;
    both = {opB, opA};
    return both[8*k +: 8];
  endfunction

endpackage

// File: rtl/fp_div_operand_feeder_if.sv
// Host plus divider-controller signal bundle for the operand feeder.
// The master modport is the feeder side and the slave modport is the host/controller side.
interface fp_div_operand_feeder_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [7:0]  res_byte;
  logic [7:0]  byte_out;
  logic        set;
  logic        unlock;
  logic        init;
  logic        sel0;
  logic        sel1;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    input  start, op_a, op_b, res_byte,
    output byte_out, set, unlock, init, sel0, sel1, busy, done, result
  );

  modport slave (
    output start, op_a, op_b, res_byte,
    input  byte_out, set, unlock, init, sel0, sel1, busy, done, result
  );
endinterface

// File: rtl/fp_div_feeder_cnt.sv
// Loadable down-counter with a zero flag.
// The count saturates at zero, and a load takes priority over counting down.
module fp_div_feeder_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/fp_div_operand_feeder.sv
// Sequences operand byte writes, the init pulse and result readback for the byte-serial divider.
// Readback is enabled with FP_DIV_FEEDER_READBACK_EN; without it, WAIT goes straight to DONE.
module fp_div_operand_feeder
  import fp_div_feeder_pkg::*;
#(
  parameter int INIT_CYCLES = 1,
  parameter int DIV_LATENCY = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  fp_div_operand_feeder_if.master bus
);

  feeder_state_t r_state;
  logic [31:0]   r_opA;
  logic [31:0]   r_opB;
  logic [2:0]    r_idx;
  logic [7:0]    r_byteOut;
  logic          r_set;
  logic          r_unlock;
  logic          r_init;
  logic          r_busy;
  logic          r_done;
  logic          w_cntLoad;
  logic [7:0]    w_cntValue;
  logic          w_cntZero;

`ifdef FP_DIV_FEEDER_READBACK_EN
  logic [1:0]    r_sel;
  logic [31:0]   r_result;
`endif

  fp_div_feeder_cnt #(.WIDTH(8)) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_cntLoad),
    .i_value (w_cntValue),
    .o_zero  (w_cntZero)
  );

  // The counter is loaded on the edge that enters each timed phase, so the phase ends when it reaches zero.
  always_comb begin
    w_cntLoad  = 1'b0;
    w_cntValue = '0;
    case (r_state)
      UNLOCK: if (r_idx == LAST_OPERAND_IDX) begin
        w_cntLoad  = 1'b1;
        w_cntValue = 8'(INIT_CYCLES - 1);
      end
      GO: if (w_cntZero) begin
        w_cntLoad  = 1'b1;
        w_cntValue = 8'(DIV_LATENCY - 1);
      end
`ifdef FP_DIV_FEEDER_READBACK_EN
      WAIT: if (w_cntZero) begin
        w_cntLoad  = 1'b1;
        w_cntValue = 8'd1;
      end
      READ: if (w_cntZero && (r_idx[1:0] != 2'(NUM_RESULT_BYTES - 1))) begin
        w_cntLoad  = 1'b1;
        w_cntValue = 8'd1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_opA     <= '0;
      r_opB     <= '0;
      r_idx     <= '0;
      r_byteOut <= '0;
      r_set     <= 1'b0;
      r_unlock  <= 1'b0;
      r_init    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef FP_DIV_FEEDER_READBACK_EN
      r_sel     <= '0;
      r_result  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_opA    <= bus.op_a;
          r_opB    <= bus.op_b;
          r_idx    <= '0;
          r_unlock <= 1'b1;
          r_init   <= 1'b1;
          r_busy   <= 1'b1;
          r_state  <= CLEAR;
`ifdef FP_DIV_FEEDER_READBACK_EN
          r_result <= '0;
`endif
        end
        CLEAR: begin
          r_unlock  <= 1'b0;
          r_init    <= 1'b0;
          r_set     <= 1'b1;
          r_byteOut <= byte_of(r_opA, r_opB, 3'd0);
          r_state   <= SET;
        end
        SET: begin
          r_set    <= 1'b0;
          r_unlock <= 1'b1;
          r_state  <= UNLOCK;
        end
        UNLOCK: begin
          r_unlock <= 1'b0;
          if (r_idx == LAST_OPERAND_IDX) begin
            r_byteOut <= '0;
            r_init    <= 1'b1;
            r_state   <= GO;
          end else begin
            r_idx     <= r_idx + 3'd1;
            r_set     <= 1'b1;
            r_byteOut <= byte_of(r_opA, r_opB, r_idx + 3'd1);
            r_state   <= SET;
          end
        end
        GO: if (w_cntZero) begin
          r_init  <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: if (w_cntZero) begin
`ifdef FP_DIV_FEEDER_READBACK_EN
          r_idx   <= '0;
          r_sel   <= 2'd0;
          r_state <= READ;
`else
          r_done  <= 1'b1;
          r_state <= DONE;
`endif
        end
`ifdef FP_DIV_FEEDER_READBACK_EN
        // The first cycle of each byte lets the controller's output mux settle before capture.
        READ: if (w_cntZero) begin
          r_result[8*r_idx[1:0] +: 8] <= bus.res_byte;
          if (r_idx[1:0] == 2'(NUM_RESULT_BYTES - 1)) begin
            r_sel   <= 2'd0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_sel   <= r_idx[1:0] + 2'd1;
          end
        end
`endif
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.byte_out = r_byteOut;
  assign bus.set      = r_set;
  assign bus.unlock   = r_unlock;
  assign bus.init     = r_init;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

`ifdef FP_DIV_FEEDER_READBACK_EN
  assign bus.sel0   = r_sel[0];
  assign bus.sel1   = r_sel[1];
  assign bus.result = r_result;
`else
  logic w_unusedResByte;
  assign w_unusedResByte = ^bus.res_byte;
  assign bus.sel0   = 1'b0;
  assign bus.sel1   = 1'b0;
  assign bus.result = '0;
`endif

endmodule

// File: tb/tb_fp_div_operand_feeder.sv
// Directed bench for fp_div_operand_feeder with a behavioural byte-serial controller model.
// Expected latency and result follow FP_DIV_FEEDER_READBACK_EN.
module tb_fp_div_operand_feeder;

`ifdef FP_DIV_FEEDER_READBACK_EN
  localparam int          LATENCY    = 90;
  localparam logic [31:0] EXP_RESULT = 32'hC0000000;
`else
  localparam int          LATENCY    = 82;
  localparam logic [31:0] EXP_RESULT = 32'h00000000;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fp_div_operand_feeder_if bus ();

  fp_div_operand_feeder #(.INIT_CYCLES(1), .DIV_LATENCY(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Controller model: set writes a byte and locks, unlock advances, init rewinds the byte counter.
  logic [7:0]  modelNum [8];
  logic        modelLock = 1'b0;
  int          modelCount = 0;
  logic [7:0]  setLog [$];
  int          overlapCount = 0;
  int          doneTotal = 0;
  logic [31:0] resModel = 32'hC0000000;
  logic [7:0]  expBytes [8] = '{8'hDB, 8'h0F, 8'h49, 8'h40, 8'h00, 8'h00, 8'h80, 8'h3F};

  assign bus.res_byte = resModel[8*{bus.sel1, bus.sel0} +: 8];

  always @(posedge clock) begin
    if (bus.set && bus.unlock) overlapCount <= overlapCount + 1;
    if (bus.done) doneTotal <= doneTotal + 1;
    if (bus.init) begin
      modelCount <= 0;
      if (bus.unlock) modelLock <= 1'b0;
    end else if (bus.unlock && modelLock) begin
      modelLock  <= 1'b0;
      modelCount <= modelCount + 1;
    end else if (bus.set && !modelLock && modelCount < 8) begin
      modelNum[modelCount] <= bus.byte_out;
      modelLock <= 1'b1;
      setLog.push_back(bus.byte_out);
    end
  end

  function automatic logic [31:0] modelA();
    return {modelNum[3], modelNum[2], modelNum[1], modelNum[0]};
  endfunction

  function automatic logic [31:0] modelB();
    return {modelNum[7], modelNum[6], modelNum[5], modelNum[4]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Runs from the accept edge to done; cycles counts edges after the accept edge.
  task automatic runToDone(input bit pokeBusy, output int cycles, output bit selSeen);
    cycles  = 0;
    selSeen = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.sel0 || bus.sel1) selSeen = 1'b1;
      if (cycles == 0) begin
        checkOutput("clear_unlock", bus.unlock, 1);
        checkOutput("clear_init", bus.init, 1);
        checkOutput("busy_rise", bus.busy, 1);
      end
      if (pokeBusy && cycles == 20) begin
        bus.start = 1'b1;
        bus.op_a  = 32'hDEADBEEF;
        bus.op_b  = 32'h01020304;
      end
      if (pokeBusy && cycles == 21) bus.start = 1'b0;
      if (bus.done || cycles >= 200) break;
      @(posedge clock);
      cycles++;
    end
  endtask

  initial begin
    int  cycles;
    bit  selSeen;
    int  base;
    int  doneBase;
    int  guard;

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    #1;
    checkOutput("reset_ctrl", {bus.byte_out, bus.set, bus.unlock, bus.init, bus.sel0, bus.sel1, bus.busy, bus.done}, 0);
    checkOutput("reset_result", bus.result, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Load, divide and read back, with an ignored start while busy.
    base     = setLog.size();
    doneBase = doneTotal;
    applyStimulus(32'h40490FDB, 32'h3F800000);
    runToDone(1'b1, cycles, selSeen);
    checkOutput("done_seen", bus.done, 1);
    checkOutput("latency", cycles, LATENCY);
    checkOutput("busy_at_done", bus.busy, 1);
    checkOutput("result", bus.result, EXP_RESULT);
`ifdef FP_DIV_FEEDER_READBACK_EN
    checkOutput("sel_used", selSeen, 1);
`else
    checkOutput("sel_idle", selSeen, 0);
`endif
    @(negedge clock);
    checkOutput("busy_fall", bus.busy, 0);
    checkOutput("done_fall", bus.done, 0);
    repeat (30) @(negedge clock);
    checkOutput("set_count", setLog.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (setLog.size() > base + i) checkOutput($sformatf("set_byte%0d", i), setLog[base + i], expBytes[i]);
      else checkOutput($sformatf("set_byte%0d", i), 0, expBytes[i]);
    end
    checkOutput("numA", modelA(), 32'h40490FDB);
    checkOutput("numB", modelB(), 32'h3F800000);
    checkOutput("done_once", doneTotal - doneBase, 1);
    checkOutput("result_held", bus.result, EXP_RESULT);

    // Abort after the third byte write, leaving the model locked.
    base     = setLog.size();
    doneBase = doneTotal;
    applyStimulus(32'hAAAA5555, 32'h5555AAAA);
    guard = 0;
    while (setLog.size() < base + 3 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("abort_reach", setLog.size() - base, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_ctrl", {bus.byte_out, bus.set, bus.unlock, bus.init, bus.sel0, bus.sel1, bus.busy, bus.done}, 0);
    checkOutput("abort_result", bus.result, 0);
    checkOutput("stale_lock", modelLock, 1);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(32'h12345678, 32'h9ABCDEF0);
    runToDone(1'b0, cycles, selSeen);
    checkOutput("abort_latency", cycles, LATENCY);
    checkOutput("abort_result2", bus.result, EXP_RESULT);
    repeat (5) @(negedge clock);
    checkOutput("abort_numA", modelA(), 32'h12345678);
    checkOutput("abort_numB", modelB(), 32'h9ABCDEF0);
    checkOutput("abort_done_once", doneTotal - doneBase, 1);
    checkOutput("no_overlap", overlapCount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
